phase_offset_est: RTL and testbench
===================================

Name: phase_offset_est

Overview:
Downstream consumer of the phase (atan) stage. It collects a block of 2^LOG2_NUM_SAMPLES phase samples after a start pulse and computes their circular mean using wrap-safe unwrapping relative to the first sample. It then divides the mean by the correlation lag to produce a per-sample frequency-offset phase increment. The sync/rotation logic uses this increment to de-rotate samples.

Parameters:
PHASE_WIDTH, 16, width of signed phase in/out
PI, 1608, integer value of pi in phase units (phase range [-PI, PI))
LOG2_NUM_SAMPLES, 4, log2 of samples averaged (N = 16)
LOG2_LAG, 4, log2 of correlation lag; mean phase is divided by 2^LOG2_LAG

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  global clock enable
start  in  1  one-cycle pulse; begins/restarts a measurement
phase_in  in  PHASE_WIDTH  signed phase sample in [-PI, PI)
phase_in_strobe  in  1  phase_in valid
offset  out  PHASE_WIDTH  signed per-sample phase increment (registered)
offset_strobe  out  1  one-cycle pulse: offset updated
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high; clock clock): state=IDLE, offset=0, offset_strobe=0, busy=0, accumulator/counter/reference cleared. Reset mid-measurement aborts it; no strobe is produced.
- enable=0 at an edge: all state holds, except offset_strobe, which clears to 0. Sample strobes at that edge are dropped.
- States: IDLE, COLLECT, MEAN, EMIT.
- IDLE: phase_in_strobe is ignored. On start=1, go to COLLECT with acc=0 and count=0.
- COLLECT, on each accepted strobe:
  - count==0: ref <= phase_in; acc += 0.
  - otherwise: d = phase_in - ref, computed at PHASE_WIDTH+1 bits. If d >= PI then d -= 2*PI; if d < -PI then d += 2*PI. Then acc += d.
  - acc is signed, PHASE_WIDTH+1+LOG2_NUM_SAMPLES bits; no overflow is possible.
  - On the edge accepting sample N-1 (count==N-1), go to MEAN.
- start=1 in COLLECT restarts: acc and count are cleared and the same-edge strobe is ignored. start in MEAN/EMIT is ignored.
- MEAN: m <= ref + (acc >>> LOG2_NUM_SAMPLES), using an arithmetic (floor) shift and PHASE_WIDTH+2 bits. Then go to EMIT.
- EMIT:
  - Wrap m: if m >= PI then m - 2*PI; if m < -PI then m + 2*PI. A single correction suffices because ref is in [-PI, PI) and the mean diff is in [-PI, PI).
  - offset <= wrapped >>>LOG2_LAG (floor); offset_strobe <= 1; go to IDLE.
- Latency: the last sample is accepted at edge E. offset and offset_strobe are registered at E+2 (with enable high throughout), so the strobe is high for the cycle following E+2.
- offset holds its value until the next EMIT or reset.
- busy is combinational from state (state != IDLE).
- A start coinciding with the EMIT edge is ignored; a new start is accepted from IDLE on the next cycle.

Test Plan:
- Constant phase: start, then 16 strobes with phase_in=800 -> exactly one offset_strobe, offset=50, strobe registered 2 edges after the 16th sample; busy falls with it.
- Negative constant: 16 samples of -800 -> offset=-50.
- Wrap boundary: 16 samples alternating 1600, -1600 (ref 1600) -> diffs 16 each, acc=128, m=1608, wrapped to -1608 -> offset=-101 (floor).
- Restart: start, 5 samples of 999, start again, then 16 samples of 160 -> single strobe, offset=10.
- Reset/idle: strobes with no start -> no strobe, busy=0. Reset asserted after 7 samples -> busy=0, offset=0, no strobe; a subsequent full measurement of 320 -> offset=20.
- Enable stall: enable low for 3 cycles after sample 8, with a strobe pulsed during the stall (dropped), then remaining 8 samples of 800 -> offset=50, latency extended by the stall length only.

Source files
------------

// File: rtl/phase_offset_est.sv
// Circular-mean phase offset estimator: averages 2^LOG2_NUM_SAMPLES phase samples, unwrapped against the first sample, then divides by the correlation lag.
// Latency: offset/offset_strobe registered two enabled edges after the edge accepting the last sample.
// Backpressure: none; enable=0 freezes all state, drops same-edge sample strobes and clears offset_strobe.
module phase_offset_est #(
  parameter int PHASE_WIDTH      = 16,
  parameter int PI               = 1608,
  parameter int LOG2_NUM_SAMPLES = 4,
  parameter int LOG2_LAG         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start,
  input  logic signed [PHASE_WIDTH-1:0] phase_in,
  input  logic                          phase_in_strobe,
  output logic signed [PHASE_WIDTH-1:0] offset,
  output logic                          offset_strobe,
  output logic                          busy
);

  // Difference, accumulator and mean widths; the accumulator cannot overflow
  // because N differences in [-PI, PI) fit in DW + LOG2_NUM_SAMPLES bits.
  localparam int DW = PHASE_WIDTH + 1;
  localparam int AW = PHASE_WIDTH + 1 + LOG2_NUM_SAMPLES;
  localparam int MW = PHASE_WIDTH + 2;

  localparam logic signed [DW-1:0] PI_D     = DW'(PI);
  localparam logic signed [DW-1:0] TWO_PI_D = DW'(2 * PI);
  localparam logic signed [MW-1:0] PI_M     = MW'(PI);
  localparam logic signed [MW-1:0] TWO_PI_M = MW'(2 * PI);
  localparam logic [LOG2_NUM_SAMPLES-1:0] LAST_CNT = '1;

  typedef enum logic [1:0] {IDLE, COLLECT, MEAN, EMIT} state_t;

  state_t                          state_q, state_d;
  logic signed [AW-1:0]            acc_q, acc_d;
  logic [LOG2_NUM_SAMPLES-1:0]     count_q, count_d;
  logic signed [PHASE_WIDTH-1:0]   ref_q, ref_d;
  logic signed [MW-1:0]            m_q, m_d;
  logic signed [PHASE_WIDTH-1:0]   offset_q, offset_d;
  logic                            strobe_q, strobe_d;

  logic signed [DW-1:0]            diff_raw, diff_wrap;
  logic signed [MW-1:0]            m_wrap;

  // Wrap-safe datapath: sample difference to the reference and wrapped mean.
  always_comb begin
    diff_raw  = DW'(phase_in) - DW'(ref_q);
    diff_wrap = diff_raw;
    if (diff_raw >= PI_D) begin
      diff_wrap = diff_raw - TWO_PI_D;
    end else if (diff_raw < -PI_D) begin
      diff_wrap = diff_raw + TWO_PI_D;
    end
    m_wrap = m_q;
    if (m_q >= PI_M) begin
      m_wrap = m_q - TWO_PI_M;
    end else if (m_q < -PI_M) begin
      m_wrap = m_q + TWO_PI_M;
    end
  end

  // Next-state logic; a low enable holds everything but lets the strobe drop.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    ref_d    = ref_q;
    m_d      = m_q;
    offset_d = offset_q;
    strobe_d = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = COLLECT;
            acc_d   = '0;
            count_d = '0;
          end
        end
        COLLECT: begin
          if (start) begin
            acc_d   = '0;
            count_d = '0;
          end else if (phase_in_strobe) begin
            if (count_q == '0) begin
              ref_d = phase_in;
            end else begin
              acc_d = acc_q + AW'(diff_wrap);
            end
            count_d = count_q + LOG2_NUM_SAMPLES'(1);
            if (count_q == LAST_CNT) begin
              state_d = MEAN;
            end
          end
        end
        MEAN: begin
          m_d     = MW'(ref_q) + MW'(acc_q >>> LOG2_NUM_SAMPLES);
          state_d = EMIT;
        end
        EMIT: begin
          offset_d = PHASE_WIDTH'(m_wrap >>> LOG2_LAG);
          strobe_d = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      ref_q    <= '0;
      m_q      <= '0;
      offset_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      ref_q    <= ref_d;
      m_q      <= m_d;
      offset_q <= offset_d;
      strobe_q <= strobe_d;
    end
  end

  assign offset        = offset_q;
  assign offset_strobe = strobe_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_phase_offset_est.sv
// Scoreboard bench for phase_offset_est: directed measurements push expected offset and strobe cycle; a monitor pops on each offset_strobe.
// Latency: expected strobe is observed at the negedge following edge E+2 of the last accepted sample.
// Backpressure: exercised through enable stalls; no ready signal on this block.
module tb_phase_offset_est;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               start;
  logic signed [15:0] phase_in;
  logic               phase_in_strobe;
  logic signed [15:0] offset;
  logic               offset_strobe;
  logic               busy;

  phase_offset_est #(
    .PHASE_WIDTH(16), .PI(1608), .LOG2_NUM_SAMPLES(4), .LOG2_LAG(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .phase_in(phase_in), .phase_in_strobe(phase_in_strobe),
    .offset(offset), .offset_strobe(offset_strobe), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int last_e = 0;
  int exp_off[$];
  int exp_cyc[$];

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Drive one cycle of inputs at the negedge; last_e records the edge index.
  task automatic step(input logic st, input logic en, input logic stb, input int ph);
    @(negedge clock);
    start = st; enable = en; phase_in_strobe = stb; phase_in = 16'(ph);
    @(posedge clock);
    #1;
    last_e = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  // Start pulse then 16 samples alternating a (even) / b (odd).
  task automatic measure(input int a, input int b, input int expected);
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? a : b);
    exp_off.push_back(expected);
    exp_cyc.push_back(last_e + 2);
  endtask

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (offset_strobe) begin
      if (exp_off.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_strobe: offset %0d at cycle %0d, required no strobe", offset, cyc);
      end else begin
        check("offset", int'(offset), exp_off.pop_front());
        check("strobe_cycle", cyc, exp_cyc.pop_front());
        check("busy_at_strobe", int'(busy), 0);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; phase_in_strobe = 1'b0; phase_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_offset", int'(offset), 0);
    check("reset_strobe", int'(offset_strobe), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;

    // Constant positive and negative phase.
    measure(800, 800, 50);
    idle(4);
    measure(-800, -800, -50);
    idle(4);

    // Wrap boundary: 1600/-1600 unwrap to +16 steps, mean wraps to -PI.
    measure(1600, -1600, -101);
    idle(4);

    // Restart mid-collection; the strobe on the restart edge is ignored.
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 999);
    step(1'b1, 1'b1, 1'b1, 500);
    check("busy_after_restart", int'(busy), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 160);
    exp_off.push_back(10);
    exp_cyc.push_back(last_e + 2);
    idle(4);

    // Strobes in IDLE are ignored.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 700);
    check("idle_busy", int'(busy), 0);

    // Reset aborts a measurement and clears offset.
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 700);
    check("collect_busy", int'(busy), 1);
    @(negedge clock);
    reset = 1'b1; phase_in_strobe = 1'b0;
    @(posedge clock);
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_offset", int'(offset), 0);
    @(negedge clock);
    reset = 1'b0;
    idle(4);
    measure(320, 320, 20);
    idle(4);

    // Enable stall with a dropped strobe in the middle.
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 800);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1600);
    step(1'b0, 1'b0, 1'b0, 0);
    check("stall_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 800);
    exp_off.push_back(50);
    exp_cyc.push_back(last_e + 2);
    idle(6);

    check("scoreboard_drained", exp_off.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
